// File: rtl/q_tile_scheduler_pkg.sv
// ============================================================================
// Module      : q_tile_scheduler_pkg
// Description : Shared types and constants for the Q tile scheduler slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NUM_PES
`define NUM_PES 4
`endif
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 8
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

package q_tile_scheduler_pkg;

  localparam int c_addr_width = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BANK = 3'd1,
    ST_START     = 3'd2,
    ST_LAUNCH    = 3'd3,
    ST_WAIT_PE   = 3'd4,
    ST_RELEASE   = 3'd5,
    ST_DONE      = 3'd6
  } sched_state_t;

  // Credits span 0..2*rows (two banks of rows in flight).
  function automatic int credit_width(input int num_rows);
    return $clog2(2 * num_rows + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/q_addr_gen.sv
// ============================================================================
// Module      : q_addr_gen
// Description : Row request address generator with two-bank credit throttling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_addr_gen
  import q_tile_scheduler_pkg::*;
#(
  parameter int NUM_ROWS       = 4,
  parameter int ADDR_WIDTH     = c_addr_width,
  parameter int TILE_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      job_start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [ADDR_WIDTH-1:0]     row_stride,
  input  logic [TILE_CNT_WIDTH-1:0] num_tiles,
  input  logic                      bank_release,
  output logic                      mem_req_valid,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic                      mem_req_ready
);

  localparam int c_row_cnt_width = TILE_CNT_WIDTH + $clog2(NUM_ROWS + 1);
  localparam int c_credit_width  = credit_width(NUM_ROWS);
  localparam int c_sum_width     = c_credit_width + 1;

  localparam logic [c_credit_width-1:0]  c_credit_max    = c_credit_width'(2 * NUM_ROWS);
  localparam logic [c_row_cnt_width-1:0] c_rows_per_tile = c_row_cnt_width'(NUM_ROWS);

  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [ADDR_WIDTH-1:0]      r_stride;
  logic [c_row_cnt_width-1:0] r_total;
  logic [c_row_cnt_width-1:0] r_req_cnt;
  logic [c_credit_width-1:0]  r_credits;
  logic [c_credit_width-1:0]  w_credits_next;
  logic [c_sum_width-1:0]     w_credits_sum;
  logic                       w_req_fire;

  // Valid depends only on registered state, so it cannot drop while stalled.
  assign mem_req_valid = (r_credits != '0) && (r_req_cnt < r_total);
  assign mem_req_addr  = r_addr;
  assign w_req_fire    = mem_req_valid && mem_req_ready;

  always_comb begin
    w_credits_sum = {1'b0, r_credits};
    if (bank_release) begin
      w_credits_sum = w_credits_sum + c_sum_width'(NUM_ROWS);
    end
    if (w_req_fire) begin
      w_credits_sum = w_credits_sum - c_sum_width'(1);
    end
    if (w_credits_sum > {1'b0, c_credit_max}) begin
      w_credits_next = c_credit_max;
    end else begin
      w_credits_next = w_credits_sum[c_credit_width-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_stride  <= '0;
      r_total   <= '0;
      r_req_cnt <= '0;
      r_credits <= '0;
    end else if (job_start) begin
      r_addr    <= base_addr;
      r_stride  <= row_stride;
      r_total   <= c_row_cnt_width'(num_tiles) * c_rows_per_tile;
      r_req_cnt <= '0;
      r_credits <= c_credit_max;
    end else begin
      r_credits <= w_credits_next;
      if (w_req_fire) begin
        r_addr    <= r_addr + r_stride;
        r_req_cnt <= r_req_cnt + c_row_cnt_width'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/q_tile_scheduler.sv
// ============================================================================
// Module      : q_tile_scheduler
// Description : Streams Q tiles into a double-banked buffer and sequences PEs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_tile_scheduler
  import q_tile_scheduler_pkg::*;
#(
  parameter int NUM_ROWS       = `NUM_PES,
  parameter int ROW_WIDTH      = `MAX_EMBEDDING_DIM * `INTEGER_WIDTH,
  parameter int ADDR_WIDTH     = c_addr_width,
  parameter int TILE_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [ADDR_WIDTH-1:0]     row_stride,
  input  logic [TILE_CNT_WIDTH-1:0] num_tiles,
  output logic                      busy,
  output logic                      done,
  output logic [TILE_CNT_WIDTH-1:0] tile_idx,
  output logic                      mem_req_valid,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic                      mem_req_ready,
  input  logic                      mem_rsp_valid,
  input  logic [ROW_WIDTH-1:0]      mem_rsp_data,
  output logic                      mem_rsp_ready,
  output logic                      buf_load_valid,
  output logic [ROW_WIDTH-1:0]      buf_load_data,
  input  logic                      buf_load_ready,
  output logic                      buf_compute_start,
  output logic                      buf_compute_done,
  input  logic                      buf_bank_full,
  output logic                      pe_start,
  input  logic                      pe_done
);

  sched_state_t              r_state;
  logic [TILE_CNT_WIDTH-1:0] r_num_tiles;
  logic [TILE_CNT_WIDTH-1:0] w_next_idx;
  logic                      w_accept;

  assign w_accept   = start && !busy && (r_state == ST_IDLE);
  assign w_next_idx = tile_idx + TILE_CNT_WIDTH'(1);

  assign buf_load_valid = mem_rsp_valid;
  assign buf_load_data  = mem_rsp_data;
  assign mem_rsp_ready  = buf_load_ready;

  q_addr_gen #(
    .NUM_ROWS       (NUM_ROWS),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .TILE_CNT_WIDTH (TILE_CNT_WIDTH)
  ) u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .job_start     (w_accept),
    .base_addr     (base_addr),
    .row_stride    (row_stride),
    .num_tiles     (num_tiles),
    .bank_release  (buf_compute_done),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready)
  );

  // Pulse outputs are set on the transition into their state so each is high
  // for exactly the one cycle the FSM spends there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= ST_IDLE;
      r_num_tiles       <= '0;
      tile_idx          <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      buf_compute_start <= 1'b0;
      buf_compute_done  <= 1'b0;
      pe_start          <= 1'b0;
    end else begin
      done              <= 1'b0;
      buf_compute_start <= 1'b0;
      buf_compute_done  <= 1'b0;
      pe_start          <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_num_tiles <= num_tiles;
            tile_idx    <= '0;
            busy        <= 1'b1;
            if (num_tiles == '0) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
            end else begin
              r_state <= ST_WAIT_BANK;
            end
          end
        end
        ST_WAIT_BANK: begin
          if (buf_bank_full) begin
            r_state           <= ST_START;
            buf_compute_start <= 1'b1;
          end
        end
        ST_START: begin
          r_state  <= ST_LAUNCH;
          pe_start <= 1'b1;
        end
        ST_LAUNCH: begin
          r_state <= ST_WAIT_PE;
        end
        ST_WAIT_PE: begin
          if (pe_done) begin
            r_state          <= ST_RELEASE;
            buf_compute_done <= 1'b1;
          end
        end
        ST_RELEASE: begin
          tile_idx <= w_next_idx;
          if (w_next_idx == r_num_tiles) begin
            r_state <= ST_DONE;
            done    <= 1'b1;
          end else begin
            r_state <= ST_WAIT_BANK;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_q_tile_scheduler.sv
// ============================================================================
// Module      : tb_q_tile_scheduler
// Description : Directed self-checking bench with memory, buffer and PE models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_q_tile_scheduler;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int RW = 64;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] row_stride = '0;
  logic [TW-1:0] num_tiles = '0;
  logic          busy, done;
  logic [TW-1:0] tile_idx;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready = 1'b1;
  logic          mem_rsp_valid = 1'b0;
  logic [RW-1:0] mem_rsp_data = '0;
  logic          mem_rsp_ready;
  logic          buf_load_valid;
  logic [RW-1:0] buf_load_data;
  logic          buf_load_ready = 1'b1;
  logic          buf_compute_start, buf_compute_done;
  logic          buf_bank_full = 1'b0;
  logic          pe_start;
  logic          pe_done = 1'b0;

  q_tile_scheduler #(
    .NUM_ROWS(NR), .ROW_WIDTH(RW), .ADDR_WIDTH(AW), .TILE_CNT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .row_stride(row_stride), .num_tiles(num_tiles), .busy(busy), .done(done),
    .tile_idx(tile_idx), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
    .buf_load_valid(buf_load_valid), .buf_load_data(buf_load_data),
    .buf_load_ready(buf_load_ready), .buf_compute_start(buf_compute_start),
    .buf_compute_done(buf_compute_done), .buf_bank_full(buf_bank_full),
    .pe_start(pe_start), .pe_done(pe_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model state and monitors
  int            cyc = 0;
  logic          acc_prev, load_prev, bcd_prev, pes_prev;
  logic [AW-1:0] addr_prev;
  int            rows_avail, pe_cnt, pe_delay;
  logic          pe_inject;
  int            stall_row, stall_left;
  logic          prev_stalled;
  logic [AW-1:0] stall_addr;
  int            n_req, n_bcs, n_pes, n_bcd, n_done;
  int            stall_cycles, stab_err, credit_err, valid_cycles, busy_cycles;
  int            cyc_bcs, cyc_pes, cyc_ped, cyc_bcd, cyc_done, cyc_start;
  int            req_at_first_bcd;
  logic          busy_at_done;
  logic [AW-1:0] addr_log[$];
  logic [TW-1:0] tile_log[$];

  task automatic clear_models();
    acc_prev = 0; load_prev = 0; bcd_prev = 0; pes_prev = 0; addr_prev = '0;
    rows_avail = 0; pe_cnt = 0; pe_inject = 0; stall_row = -1; stall_left = 0;
    mem_rsp_valid = 0; mem_rsp_data = '0; buf_bank_full = 0; pe_done = 0;
    mem_req_ready = 1; prev_stalled = 0; stall_addr = '0;
  endtask

  task automatic clear_mon();
    n_req = 0; n_bcs = 0; n_pes = 0; n_bcd = 0; n_done = 0;
    stall_cycles = 0; stab_err = 0; credit_err = 0; valid_cycles = 0; busy_cycles = 0;
    cyc_bcs = -1; cyc_pes = -1; cyc_ped = -1; cyc_bcd = -1; cyc_done = -1;
    req_at_first_bcd = -1; busy_at_done = 0;
    addr_log.delete(); tile_log.delete();
  endtask

  // One clock: apply model responses at edge+1, sample outputs at edge+2.
  task automatic tick();
    logic acc;
    @(posedge clk);
    #1;
    cyc++;
    mem_rsp_valid = acc_prev;
    mem_rsp_data  = {{(RW-AW){1'b0}}, addr_prev};
    if (load_prev) rows_avail++;
    if (bcd_prev) rows_avail -= NR;
    buf_bank_full = (rows_avail >= NR);
    pe_done = pe_inject;
    pe_inject = 0;
    if (pes_prev) pe_cnt = pe_delay;
    if (pe_cnt > 0) begin
      pe_cnt--;
      if (pe_cnt == 0) pe_done = 1;
    end
    mem_req_ready = 1;
    if (stall_left > 0 && mem_req_valid && n_req == stall_row) begin
      mem_req_ready = 0;
      stall_left--;
    end
    #1;
    acc = mem_req_valid && mem_req_ready;
    if (prev_stalled && !(mem_req_valid && mem_req_addr == stall_addr)) stab_err++;
    prev_stalled = mem_req_valid && !mem_req_ready;
    stall_addr   = mem_req_addr;
    if (prev_stalled) stall_cycles++;
    if (acc) begin
      addr_log.push_back(mem_req_addr);
      n_req++;
    end
    if (n_req - NR * n_bcd > 2 * NR) credit_err++;
    if (mem_req_valid) valid_cycles++;
    if (busy) busy_cycles++;
    if (buf_compute_start) begin n_bcs++; cyc_bcs = cyc; end
    if (pe_start) begin n_pes++; cyc_pes = cyc; tile_log.push_back(tile_idx); end
    if (pe_done) cyc_ped = cyc;
    if (buf_compute_done) begin
      if (n_bcd == 0) req_at_first_bcd = n_req;
      n_bcd++;
      cyc_bcd = cyc;
    end
    if (done) begin n_done++; cyc_done = cyc; busy_at_done = busy; end
    acc_prev  = acc;
    addr_prev = mem_req_addr;
    load_prev = buf_load_valid && buf_load_ready;
    bcd_prev  = buf_compute_done;
    pes_prev  = pe_start;
  endtask

  task automatic do_reset();
    start = 0;
    rst_n = 0;
    clear_models();
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    clear_mon();
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [TW-1:0] n);
    base_addr = b; row_stride = s; num_tiles = n; start = 1;
    tick();
    start = 0;
    cyc_start = cyc;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (n_done == 0 && k < budget) begin tick(); k++; end
    n_checks++;
    if (n_done == 0) $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    else n_pass++;
    tick(); tick();
  endtask

  function automatic int addr_errors(input logic [AW-1:0] b, input logic [AW-1:0] s, input int cnt);
    int e = 0;
    for (int k = 0; k < cnt; k++) begin
      logic [AW-1:0] exp_a;
      exp_a = b + AW'(k) * s;
      if (k >= addr_log.size() || addr_log[k] !== exp_a) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    logic [53:0] outs;
    #2 rst_n = 0;
    #1;
    outs = {busy, done, mem_req_valid, buf_compute_start, buf_compute_done, pe_start, tile_idx, mem_req_addr};
    n_checks++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs); else n_pass++;
    do_reset();
  endtask

  task automatic test_pass_through();
    mem_rsp_valid = 1; mem_rsp_data = 64'hA5A5_0000_1234_5678; buf_load_ready = 0;
    #1;
    n_checks++;
    if ({buf_load_valid, buf_load_data, mem_rsp_ready} !== {1'b1, 64'hA5A5_0000_1234_5678, 1'b0})
      $display("FAIL pass_through_a: got %b/%h/%b expected 1/a5a5000012345678/0",
               buf_load_valid, buf_load_data, mem_rsp_ready);
    else n_pass++;
    mem_rsp_valid = 0; buf_load_ready = 1;
    #1;
    n_checks++;
    if ({buf_load_valid, mem_rsp_ready} !== 2'b01)
      $display("FAIL pass_through_b: got %b/%b expected 0/1", buf_load_valid, mem_rsp_ready);
    else n_pass++;
    mem_rsp_data = '0;
  endtask

  task automatic test_single_tile();
    int e;
    do_reset();
    pe_delay = 3;
    start_job(32'h1000, 32'h40, 16'd1);
    wait_done(200, "single");
    e = addr_errors(32'h1000, 32'h40, 4);
    n_checks++;
    if (n_req != 4 || e != 0) $display("FAIL single_addrs: got %0d reqs %0d bad, expected 4 reqs 0 bad", n_req, e);
    else n_pass++;
    n_checks++;
    if (n_bcs != 1 || n_pes != 1) $display("FAIL single_pulses: got bcs=%0d pes=%0d expected 1/1", n_bcs, n_pes);
    else n_pass++;
    n_checks++;
    if (cyc_pes - cyc_bcs != 1) $display("FAIL single_pe_after_bcs: got %0d expected 1", cyc_pes - cyc_bcs);
    else n_pass++;
    n_checks++;
    if (cyc_bcd - cyc_ped != 1 || cyc_done - cyc_bcd != 1)
      $display("FAIL single_release_timing: got %0d/%0d expected 1/1", cyc_bcd - cyc_ped, cyc_done - cyc_bcd);
    else n_pass++;
    n_checks++;
    if (n_done != 1 || busy_at_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL single_done_busy: got done=%0d busy@done=%b busy_after=%b expected 1/1/0", n_done, busy_at_done, busy);
    else n_pass++;
  endtask

  task automatic test_credit_throttle();
    int e;
    logic [47:0] tiles;
    do_reset();
    pe_delay = 50;
    start_job(32'h2000, 32'h10, 16'd3);
    wait_done(600, "credit");
    n_checks++;
    if (req_at_first_bcd != 8) $display("FAIL credit_stall_at_8: got %0d expected 8", req_at_first_bcd);
    else n_pass++;
    e = addr_errors(32'h2000, 32'h10, 12);
    n_checks++;
    if (n_req != 12 || e != 0) $display("FAIL credit_total_reqs: got %0d reqs %0d bad expected 12 reqs 0 bad", n_req, e);
    else n_pass++;
    n_checks++;
    if (credit_err != 0) $display("FAIL credit_outstanding: got %0d over-limit cycles expected 0", credit_err);
    else n_pass++;
    tiles = (tile_log.size() == 3) ? {tile_log[0], tile_log[1], tile_log[2]} : '1;
    n_checks++;
    if (tiles !== {16'd0, 16'd1, 16'd2}) $display("FAIL credit_tile_idx: got %h expected 000000010002", tiles);
    else n_pass++;
    n_checks++;
    if (n_done != 1 || n_bcd != 3 || tile_idx !== 16'd3)
      $display("FAIL credit_done: got done=%0d bcd=%0d idx=%0d expected 1/3/3", n_done, n_bcd, tile_idx);
    else n_pass++;
  endtask

  task automatic test_stall_hold();
    int e;
    do_reset();
    pe_delay = 2;
    stall_row = 2; stall_left = 5;
    start_job(32'h3000, 32'h20, 16'd1);
    wait_done(200, "stall");
    n_checks++;
    if (stall_cycles != 5 || stab_err != 0)
      $display("FAIL stall_hold: got %0d stall cycles %0d unstable expected 5/0", stall_cycles, stab_err);
    else n_pass++;
    e = addr_errors(32'h3000, 32'h20, 4);
    n_checks++;
    if (n_req != 4 || e != 0) $display("FAIL stall_addrs: got %0d reqs %0d bad expected 4 reqs 0 bad", n_req, e);
    else n_pass++;
  endtask

  task automatic test_zero_tiles();
    do_reset();
    start_job(32'h7000, 32'h40, 16'd0);
    repeat (5) tick();
    n_checks++;
    if (n_done != 1 || cyc_done != cyc_start || busy_cycles != 1)
      $display("FAIL zero_done: got done=%0d at +%0d busy_cycles=%0d expected 1/+0/1",
               n_done, cyc_done - cyc_start, busy_cycles);
    else n_pass++;
    n_checks++;
    if (valid_cycles != 0) $display("FAIL zero_no_reqs: got %0d valid cycles expected 0", valid_cycles);
    else n_pass++;
  endtask

  task automatic test_stray_pe_done();
    do_reset();
    pe_delay = 4;
    start_job(32'h0800, 32'h4, 16'd1);
    tick();
    pe_inject = 1;
    tick(); tick(); tick();
    n_checks++;
    if (n_bcd != 0 || n_pes != 0) $display("FAIL stray_pe_done: got bcd=%0d pes=%0d expected 0/0", n_bcd, n_pes);
    else n_pass++;
    wait_done(200, "stray");
    n_checks++;
    if (n_bcd != 1 || n_done != 1) $display("FAIL stray_complete: got bcd=%0d done=%0d expected 1/1", n_bcd, n_done);
    else n_pass++;
  endtask

  task automatic test_busy_and_abort();
    int k, e;
    logic [53:0] outs;
    do_reset();
    pe_delay = 20;
    start_job(32'h5000, 32'h10, 16'd2);
    repeat (3) tick();
    base_addr = 32'h9000; num_tiles = 16'd0; start = 1;
    tick();
    start = 0;
    k = 0;
    while (tile_idx !== 16'd1 && k < 300) begin tick(); k++; end
    n_checks++;
    if (tile_idx !== 16'd1) $display("FAIL abort_reach_tile1: got idx %0d expected 1", tile_idx);
    else n_pass++;
    e = addr_errors(32'h5000, 32'h10, 8);
    n_checks++;
    if (n_done != 0 || e != 0) $display("FAIL busy_start_ignored: got done=%0d bad_addrs=%0d expected 0/0", n_done, e);
    else n_pass++;
    rst_n = 0;
    #1;
    outs = {busy, done, mem_req_valid, buf_compute_start, buf_compute_done, pe_start, tile_idx, mem_req_addr};
    n_checks++;
    if (outs !== '0) $display("FAIL abort_outputs: got %h expected 0", outs); else n_pass++;
    do_reset();
    pe_delay = 2;
    start_job(32'h6000, 32'h8, 16'd1);
    wait_done(200, "restart");
    e = addr_errors(32'h6000, 32'h8, 4);
    n_checks++;
    if (n_req != 4 || e != 0 || tile_log.size() != 1)
      $display("FAIL restart_reqs: got %0d reqs %0d bad %0d launches expected 4/0/1", n_req, e, tile_log.size());
    else n_pass++;
    n_checks++;
    if (tile_log.size() != 1 || tile_log[0] !== 16'd0 || n_done != 1 || tile_idx !== 16'd1)
      $display("FAIL restart_from_tile0: got done=%0d idx=%0d expected 1/1 and launch at tile 0", n_done, tile_idx);
    else n_pass++;
  endtask

  initial begin
    clear_models();
    clear_mon();
    pe_delay = 1;
    test_reset();
    test_pass_through();
    test_single_tile();
    test_credit_throttle();
    test_stall_hold();
    test_zero_tiles();
    test_stray_pe_done();
    test_busy_and_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
